pvtmon_axi_master: RTL and testbench
====================================

PVTMON_AXI_MASTER -- requirements
Module: pvtmon_axi_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI-lite data width (only 32 supported).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 11, AXI-lite address width.
REQ-003 SHALL have parameter NUM_POWER_REG, default 13, number of monitor registers read per sweep.
REQ-004 SHALL have parameter BASE_ADDR, default 'h200, byte address of the first monitor register.
REQ-005 SHALL have parameter REG_STRIDE, default 4, byte address increment between registers.
REQ-006 SHALL have parameter POLL_INTERVAL, default 1000, idle cycles between sweeps (0 allowed).
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 255, per-phase wait limit (used only with PVTMON_TIMEOUT_EN).
REQ-008 SHALL have ports: M_AXI_ACLK in 1 clock; M_AXI_ARESETN in 1 reset. One clock; reset is synchronous and active-low.
REQ-009 SHALL have ports: enable in 1 run polling; power_status out NUM_POWER_REG*32 coherent snapshot, word i at [i*32+:32]; status_valid out 1 one-cycle pulse on snapshot update; err_cnt out 16 saturating error count; busy out 1 sweep in progress.
REQ-010 SHALL have read ports: M_AXI_ARADDR out ADDR; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.
REQ-011 SHALL have write ports tied off: M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID all constant 0; M_AXI_BREADY constant 1; AWREADY, WREADY, BVALID, BRESP inputs ignored.

Function
REQ-012 SHALL use FSM states IDLE, WAIT, ADDR, DATA, NEXT, DONE.
REQ-013 IDLE -> WAIT when enable=1, loading interval counter with POLL_INTERVAL.
REQ-014 WAIT SHALL decrement each cycle; at 0 -> ADDR with index=0; POLL_INTERVAL=0 gives zero WAIT cycles.
REQ-015 ADDR SHALL hold ARVALID=1, ARADDR=BASE_ADDR+index*REG_STRIDE (truncated to ADDR width), stable until ARREADY sampled 1; then -> DATA with ARVALID=0 next cycle.
REQ-016 DATA SHALL hold RREADY=1 until RVALID sampled 1; data captured into collect buffer[index] that cycle; -> NEXT.
REQ-017 ARVALID and RREADY SHALL never be high together; at most one outstanding read.
REQ-018 RRESP!=OKAY: buffer[index] SHALL keep its previous value and err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-019 NEXT: index=NUM_POWER_REG-1 -> DONE, else index+1 -> ADDR.
REQ-020 DONE SHALL copy entire buffer into power_status in one cycle, pulse status_valid for exactly one cycle, then -> WAIT if enable=1 else IDLE.
REQ-021 power_status SHALL change only in DONE; never partially updated.
REQ-022 enable deassert mid-sweep SHALL NOT abort; sweep completes, then IDLE.
REQ-023 busy SHALL be 1 in ADDR, DATA, NEXT, DONE; 0 in IDLE, WAIT.
REQ-024 Latency per register with zero-wait slave (ARREADY and RVALID high on first cycle): 3 cycles (ADDR, DATA, NEXT).

Reset
REQ-025 On M_AXI_ARESETN=0 at a clock edge: state IDLE, ARVALID=0, RREADY=0, power_status=0, buffer=0, status_valid=0, err_cnt=0, busy=0, index=0.
REQ-026 Reset mid-transaction SHALL drop ARVALID/RREADY the following cycle; no snapshot update.

Configuration
REQ-027 Macro PVTMON_TIMEOUT_EN defined: a counter SHALL run in ADDR and DATA; reaching TIMEOUT_CYCLES without handshake -> err_cnt+1, buffer[index] unchanged, channel signal dropped, -> NEXT.
REQ-028 PVTMON_TIMEOUT_EN undefined: ADDR and DATA SHALL wait indefinitely; no timeout logic synthesised.

Verification
REQ-029 Zero-wait slave returning 'h1000+i, POLL_INTERVAL=0, NUM_POWER_REG=13 -> addresses 'h200..'h230 step 4, status_valid after 39+1 cycles, word i='h1000+i.
REQ-030 ARREADY delayed 5 cycles on register 3 -> ARADDR='h20C and ARVALID stable 6 cycles, RREADY low throughout.
REQ-031 RRESP=2'b10 on register 7, previous snapshot word7='h55 -> new word7='h55, err_cnt=1, other words updated.
REQ-032 enable dropped during register 5 -> sweep finishes, one status_valid, then IDLE, no further ARVALID.
REQ-033 PVTMON_TIMEOUT_EN, TIMEOUT_CYCLES=255, RVALID never asserted on register 2 -> RREADY drops after 255 cycles, err_cnt=1, sweep continues to register 3.
REQ-034 Reset asserted during DATA -> next cycle RREADY=0, power_status=0, err_cnt=0, state IDLE.

Source files
------------

// File: rtl/pvtmon_axi_master.sv
// Sweeps NUM_POWER_REG PVT monitor registers over AXI-lite reads and publishes them as one coherent snapshot.
// Latency: 3 cycles per register with a zero-wait slave, plus one DONE cycle per sweep (POLL_INTERVAL idle cycles between sweeps).
// Backpressure: holds ARVALID/RREADY until the slave handshakes; PVTMON_TIMEOUT_EN bounds each wait to TIMEOUT_CYCLES.
module pvtmon_axi_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 11,
    parameter int NUM_POWER_REG      = 13,
    parameter int BASE_ADDR          = 'h200,
    parameter int REG_STRIDE         = 4,
    parameter int POLL_INTERVAL      = 1000,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            enable,
    output logic [NUM_POWER_REG*32-1:0]     power_status,
    output logic                            status_valid,
    output logic [15:0]                     err_cnt,
    output logic                            busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int IW = (NUM_POWER_REG > 1) ? $clog2(NUM_POWER_REG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_POWER_REG - 1);
    localparam logic [31:0] POLL_LOAD = 32'(POLL_INTERVAL);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    // A zero poll interval skips WAIT entirely rather than spending one cycle there.
    localparam logic [2:0] S_START = (POLL_INTERVAL == 0) ? S_ADDR : S_WAIT;

    logic [2:0]                  state_q, state_d;
    logic [31:0]                 wait_q, wait_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_POWER_REG*32-1:0] buf_q, buf_d;
    logic [NUM_POWER_REG*32-1:0] snap_q, snap_d;
    logic                        sv_q, sv_d;
    logic [15:0]                 err_q, err_d;
    logic [15:0]                 err_inc;
    logic                        tmo_hit;

`ifdef PVTMON_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        snap_d  = snap_q;
        sv_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_START;
                    wait_d  = POLL_LOAD;
                    idx_d   = '0;
                end
            end
            S_WAIT: begin
                if (wait_q <= 32'd1) begin
                    state_d = S_ADDR;
                    idx_d   = '0;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            S_ADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_DATA;
                end else if (tmo_hit) begin
                    err_d   = err_inc;
                    state_d = S_NEXT;
                end
            end
            S_DATA: begin
                if (M_AXI_RVALID) begin
                    // Error responses leave the previous good value in place.
                    if (M_AXI_RRESP == 2'b00) begin
                        buf_d[int'(idx_q)*32 +: 32] = 32'(M_AXI_RDATA);
                    end else begin
                        err_d = err_inc;
                    end
                    state_d = S_NEXT;
                end else if (tmo_hit) begin
                    err_d   = err_inc;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                snap_d = buf_q;
                sv_d   = 1'b1;
                idx_d  = '0;
                if (enable) begin
                    state_d = S_START;
                    wait_d  = POLL_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PVTMON_TIMEOUT_EN
    // Counts stalled cycles of the current channel; restarts at zero on every phase change.
    always_comb begin
        tmo_d = '0;
        if ((state_q == S_ADDR && !M_AXI_ARREADY) || (state_q == S_DATA && !M_AXI_RVALID)) begin
            tmo_d = tmo_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            snap_q  <= '0;
            sv_q    <= 1'b0;
            err_q   <= '0;
`ifdef PVTMON_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            snap_q  <= snap_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
`ifdef PVTMON_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign M_AXI_ARVALID = (state_q == S_ADDR);
    assign M_AXI_RREADY  = (state_q == S_DATA);
    assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(BASE_ADDR + int'(idx_q) * REG_STRIDE);
    assign busy          = (state_q == S_ADDR) || (state_q == S_DATA) ||
                           (state_q == S_NEXT) || (state_q == S_DONE);
    assign power_status  = snap_q;
    assign status_valid  = sv_q;
    assign err_cnt       = err_q;

    assign M_AXI_AWADDR  = '0;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = '0;
    assign M_AXI_WSTRB   = '0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;

    logic unused_wr_inputs;
    assign unused_wr_inputs = &{1'b0, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP};

endmodule

// File: tb/tb_pvtmon_axi_master.sv
// Directed bench for pvtmon_axi_master: behavioural AXI-lite read slave with per-register delay/error knobs.
`timescale 1ns/1ps
module tb_pvtmon_axi_master;

    localparam int N = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, enable;
    logic [N*32-1:0] power_status;
    logic          status_valid, busy;
    logic [15:0]   err_cnt;
    logic [10:0]   awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          arready, rvalid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;

    pvtmon_axi_master #(.POLL_INTERVAL(0)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .enable(enable),
        .power_status(power_status), .status_valid(status_valid), .err_cnt(err_cnt), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(1'b0),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(1'b0),
        .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b0), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int data_base;
    int ar_delay [16];
    logic [1:0] resp_cfg [16];
    bit rv_never [16];
    int ar_cycles [16];
    int rr_cycles [16];
    int addr_q [$];
    int sv_count, sv_last, sweep_start, overlap, unstable, ar_total, ar_wait, cur_reg;
    logic prev_arvalid;
    logic [10:0] prev_araddr;

    // Monitor first, then slave response for the coming posedge.
    always @(negedge clk) begin
        cyc++;
        if (status_valid === 1'b1) begin sv_count++; sv_last = cyc; end
        if (arvalid === 1'b1 && rready === 1'b1) overlap++;
        if (arvalid === 1'b1) begin
            ar_total++;
            cur_reg = (int'(araddr) - 'h200) / 4;
            if (cur_reg < 0 || cur_reg > 15) cur_reg = 15;
            ar_cycles[cur_reg]++;
            if (prev_arvalid !== 1'b1 && cur_reg == 0) sweep_start = cyc;
            if (prev_arvalid === 1'b1 && araddr !== prev_araddr) unstable++;
        end
        if (rready === 1'b1) rr_cycles[cur_reg]++;
        prev_arvalid = arvalid;
        prev_araddr  = araddr;
        if (arvalid === 1'b1) begin
            ar_wait++;
            arready = (ar_wait > ar_delay[cur_reg]);
            if (arready) addr_q.push_back(int'(araddr));
        end else begin
            ar_wait = 0;
            arready = 1'b0;
        end
        if (rready === 1'b1 && !rv_never[cur_reg]) begin
            rvalid = 1'b1;
            rdata  = 32'(data_base + cur_reg);
            rresp  = resp_cfg[cur_reg];
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rresp  = 2'b00;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) begin
            ar_delay[i] = 0; resp_cfg[i] = 2'b00; rv_never[i] = 1'b0;
            ar_cycles[i] = 0; rr_cycles[i] = 0;
        end
        addr_q.delete();
        sv_count = 0; sv_last = -1; sweep_start = -1; overlap = 0; unstable = 0; ar_total = 0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            step(1);
            if (sv_count > 0 && busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic one_sweep(input int base, output bit ok);
        data_base = base;
        enable = 1'b1; step(1); enable = 1'b0;
        wait_idle(ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        step(3);
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", rready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (status_valid !== 1'b0) begin failures++; $display("FAIL reset_status_valid got=%b exp=0", status_valid); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%h exp=0", err_cnt); end
        checks++; if (power_status !== '0) begin failures++; $display("FAIL reset_power_status nonzero"); end
        checks++; if (araddr !== 11'h200) begin failures++; $display("FAIL reset_araddr got=%h exp=200", araddr); end
        checks++; if ({awaddr, awvalid, wdata, wstrb, wvalid, bready} !== {11'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1})
            begin failures++; $display("FAIL write_tieoff aw=%h awv=%b w=%h s=%h wv=%b br=%b", awaddr, awvalid, wdata, wstrb, wvalid, bready); end
        rst_n = 1'b1;
        step(5);
        checks++; if (arvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_no_enable arvalid=%b busy=%b exp=0/0", arvalid, busy); end
    endtask

    task automatic test_sweep();
        bit ok; int c0;
        clear_stats();
        c0 = cyc;
        one_sweep('h1000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sweep_done timeout"); end
        checks++; if (sweep_start != c0 + 1) begin failures++; $display("FAIL sweep_first_ar got=%0d exp=%0d", sweep_start, c0 + 1); end
        checks++; if (sv_last - sweep_start != 40) begin failures++; $display("FAIL sweep_latency got=%0d exp=40", sv_last - sweep_start); end
        checks++; if (sv_count != 1) begin failures++; $display("FAIL sweep_sv_pulses got=%0d exp=1", sv_count); end
        checks++; if (addr_q.size() != N) begin failures++; $display("FAIL sweep_addr_count got=%0d exp=%0d", addr_q.size(), N); end
        for (int i = 0; i < addr_q.size(); i++) begin
            checks++; if (addr_q[i] != 'h200 + 4*i) begin failures++; $display("FAIL sweep_addr[%0d] got=%h exp=%h", i, addr_q[i], 'h200 + 4*i); end
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (power_status[i*32 +: 32] !== 32'('h1000 + i))
                begin failures++; $display("FAIL sweep_word[%0d] got=%h exp=%h", i, power_status[i*32 +: 32], 'h1000 + i); end
        end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL sweep_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL sweep_overlap got=%0d exp=0", overlap); end
    endtask

    task automatic test_arready_delay();
        bit ok;
        clear_stats();
        ar_delay[3] = 5;
        one_sweep('h3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ardly_done timeout"); end
        checks++; if (ar_cycles[3] != 6) begin failures++; $display("FAIL ardly_arvalid_cycles got=%0d exp=6", ar_cycles[3]); end
        checks++; if (ar_cycles[4] != 1) begin failures++; $display("FAIL ardly_other_cycles got=%0d exp=1", ar_cycles[4]); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL ardly_addr_stable got=%0d exp=0", unstable); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL ardly_rready_overlap got=%0d exp=0", overlap); end
        checks++; if (addr_q.size() != N || addr_q[3] != 'h20C) begin failures++; $display("FAIL ardly_addr3 size=%0d exp=%0d/20c", addr_q.size(), N); end
        checks++; if (sv_last - sweep_start != 45) begin failures++; $display("FAIL ardly_latency got=%0d exp=45", sv_last - sweep_start); end
        checks++; if (power_status[3*32 +: 32] !== 32'h3003) begin failures++; $display("FAIL ardly_word3 got=%h exp=3003", power_status[3*32 +: 32]); end
    endtask

    task automatic test_rresp_err();
        bit ok;
        clear_stats();
        one_sweep('h4E, ok);
        checks++; if (power_status[7*32 +: 32] !== 32'h55) begin failures++; $display("FAIL err_pre_word7 got=%h exp=55", power_status[7*32 +: 32]); end
        clear_stats();
        resp_cfg[7] = 2'b10;
        one_sweep('h2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL err_done timeout"); end
        checks++; if (power_status[7*32 +: 32] !== 32'h55) begin failures++; $display("FAIL err_word7_kept got=%h exp=55", power_status[7*32 +: 32]); end
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (power_status[6*32 +: 32] !== 32'h2006) begin failures++; $display("FAIL err_word6 got=%h exp=2006", power_status[6*32 +: 32]); end
        checks++; if (power_status[8*32 +: 32] !== 32'h2008) begin failures++; $display("FAIL err_word8 got=%h exp=2008", power_status[8*32 +: 32]); end
        checks++; if (power_status[12*32 +: 32] !== 32'h200C) begin failures++; $display("FAIL err_word12 got=%h exp=200c", power_status[12*32 +: 32]); end
    endtask

    task automatic test_enable_drop();
        bit ok; bit found; int ar_snap;
        clear_stats();
        data_base = 'h5000;
        found = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (arvalid === 1'b1 && araddr === 11'h214) found = 1'b1;
        end
        enable = 1'b0;
        checks++; if (!found) begin failures++; $display("FAIL drop_reach_reg5 timeout"); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_done timeout"); end
        checks++; if (power_status[12*32 +: 32] !== 32'h500C) begin failures++; $display("FAIL drop_word12 got=%h exp=500c", power_status[12*32 +: 32]); end
        ar_snap = ar_total;
        step(60);
        checks++; if (sv_count != 1) begin failures++; $display("FAIL drop_sv_pulses got=%0d exp=1", sv_count); end
        checks++; if (ar_total != ar_snap) begin failures++; $display("FAIL drop_extra_arvalid got=%0d exp=%0d", ar_total, ar_snap); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int t1; int t2; bit ok;
        clear_stats();
        data_base = 'h6000;
        t1 = -1; t2 = -1; ok = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 500 && t2 < 0; i++) begin
            step(1);
            if (sv_count == 1 && t1 < 0) t1 = sv_last;
            if (sv_count == 2) t2 = sv_last;
        end
        enable = 1'b0;
        checks++; if (t2 - t1 != 40) begin failures++; $display("FAIL b2b_spacing got=%0d exp=40", t2 - t1); end
        for (int i = 0; i < 500 && !ok; i++) begin
            step(1);
            if (busy === 1'b0) ok = 1'b1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL b2b_idle timeout"); end
        checks++; if (sv_count != 3) begin failures++; $display("FAIL b2b_sv_pulses got=%0d exp=3", sv_count); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
        checks++; if (power_status[0 +: 32] !== 32'h6000) begin failures++; $display("FAIL b2b_word0 got=%h exp=6000", power_status[0 +: 32]); end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_stats();
        data_base = 'h7000;
        found = 1'b0;
        enable = 1'b1; step(1); enable = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (rready === 1'b1 && cur_reg == 4) found = 1'b1;
            else step(1);
        end
        checks++; if (!found) begin failures++; $display("FAIL rstmid_reach_data timeout"); end
        rst_n = 1'b0;
        step(1);
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rstmid_rready got=%b exp=0", rready); end
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rstmid_arvalid got=%b exp=0", arvalid); end
        checks++; if (power_status !== '0) begin failures++; $display("FAIL rstmid_power_status nonzero"); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        step(50);
        checks++; if (sv_count != 0) begin failures++; $display("FAIL rstmid_no_snapshot got=%0d exp=0", sv_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle_busy got=%b exp=0", busy); end
    endtask

`ifdef PVTMON_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_stats();
        rv_never[2] = 1'b1;
        one_sweep('h8000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tmo_done timeout"); end
        checks++; if (rr_cycles[2] != 255) begin failures++; $display("FAIL tmo_rready_cycles got=%0d exp=255", rr_cycles[2]); end
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL tmo_err_cnt got=%0d exp=1", err_cnt); end
        checks++; if (addr_q.size() != N) begin failures++; $display("FAIL tmo_addr_count got=%0d exp=%0d", addr_q.size(), N); end
        checks++; if (power_status[3*32 +: 32] !== 32'h8003) begin failures++; $display("FAIL tmo_word3 got=%h exp=8003", power_status[3*32 +: 32]); end
        checks++; if (power_status[2*32 +: 32] !== 32'h0) begin failures++; $display("FAIL tmo_word2 got=%h exp=0", power_status[2*32 +: 32]); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; enable = 1'b0; data_base = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        ar_wait = 0; cur_reg = 0; prev_arvalid = 1'b0; prev_araddr = '0;
        clear_stats();
        test_reset();
        test_sweep();
        test_arready_delay();
        test_rresp_err();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef PVTMON_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
